// File: rtl/pipe_stage_chain_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stage_chain_pkg
//
// Purpose:
//    Shared definitions for the register-stage pipeline chain and its
//    forwarding muxes: default payload/address widths, the stage-record
//    layout and a small popcount helper for the occupancy counter.
//
// Contents:
//    DATA_W_DEF  - default payload width
//    ADDR_W_DEF  - default destination-register address width
//    MAX_DEPTH   - largest supported number of stages
//    stage_t     - one stage record (valid, regWrite, data, rdAddr)
//    countValid  - popcount over a MAX_DEPTH-wide valid vector
// ---------------------------------------------------------------------------
package pipe_stage_chain_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int MAX_DEPTH  = 8;

    // A single in-flight slot. The chain keeps one of these per stage; at
    // non-default widths the top keeps the same four fields as parallel
    // vectors sized by its own parameters.
    typedef struct packed {
        logic                  valid;
        logic                  regWrite;
        logic [DATA_W_DEF-1:0] data;
        logic [ADDR_W_DEF-1:0] rdAddr;
    } stage_t;

    // Counts set bits in a valid vector that has been zero-padded out to
    // MAX_DEPTH, so one helper serves every legal DEPTH.
    function automatic logic [3:0] countValid(input logic [MAX_DEPTH-1:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            cnt = cnt + 4'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_stage_chain_fwd_mux.sv
// ---------------------------------------------------------------------------
// pipe_fwd_mux
//
// Purpose:
//    One forwarding query against every stage of the pipeline chain. A stage
//    matches when it is valid, writes the register file, targets the queried
//    register and the queried register is not r0. The youngest (lowest
//    index) matching stage supplies the forwarded data.
//
// Ports:
//    stageValid_i    - per-stage valid bits
//    stageRegWrite_i - per-stage register-write bits
//    stageData_i     - per-stage payloads
//    stageRdAddr_i   - per-stage destination registers
//    qaddr_i         - queried source register
//    hit_o           - some stage matches the query
//    data_o          - payload of the youngest matching stage, else zero
// ---------------------------------------------------------------------------
module pipe_fwd_mux
    import pipe_stage_chain_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic [DEPTH-1:0]             stageValid_i,
    input  logic [DEPTH-1:0]             stageRegWrite_i,
    input  logic [DEPTH-1:0][DATA_W-1:0] stageData_i,
    input  logic [DEPTH-1:0][ADDR_W-1:0] stageRdAddr_i,
    input  logic [ADDR_W-1:0]            qaddr_i,
    output logic                         hit_o,
    output logic [DATA_W-1:0]            data_o
);

    // Walk from the oldest stage towards the youngest so that a younger
    // match simply overwrites an older one; the last write wins, which gives
    // youngest-first priority without an explicit priority encoder. Register
    // zero is hard-wired, so a query for it never forwards anything.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        if (qaddr_i != '0) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (stageValid_i[k] && stageRegWrite_i[k] &&
                    (stageRdAddr_i[k] == qaddr_i)) begin
                    hit_o  = 1'b1;
                    data_o = stageData_i[k];
                end
            end
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// pipe_stage_chain
//
// Purpose:
//    A chain of DEPTH register stages carrying instruction result slots
//    (valid, RegWrite, data, destination register) from stage 0 (youngest)
//    to stage DEPTH-1 (oldest), with stall, flush and NQ combinational
//    forwarding query ports looking into every stage.
//
// Ports:
//    clk_i        - clock, all state updates on the rising edge
//    rst_i        - synchronous active-high reset, clears every stage
//    valid_i      - incoming slot is live
//    RegWrite_i   - incoming slot writes the register file
//    data_i       - incoming payload
//    RDaddr_i     - incoming destination register
//    stall_i      - hold every stage, ignore the inputs
//    flush_i      - kill every in-flight slot and the incoming one
//    qaddr_i      - NQ packed forwarding source addresses
//    valid_o      - last stage valid
//    RegWrite_o   - last stage valid AND last stage RegWrite
//    data_o       - last stage payload
//    RDaddr_o     - last stage destination register
//    qhit_o       - per-query forwarding hit
//    qdata_o      - per-query forwarded payload, zero on miss
//    occupancy_o  - number of valid stages
// ---------------------------------------------------------------------------
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2,
    parameter int NQ     = 2,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic                 RegWrite_i,
    input  logic [DATA_W-1:0]    data_i,
    input  logic [ADDR_W-1:0]    RDaddr_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic [NQ*ADDR_W-1:0] qaddr_i,
    output logic                 valid_o,
    output logic                 RegWrite_o,
    output logic [DATA_W-1:0]    data_o,
    output logic [ADDR_W-1:0]    RDaddr_o,
    output logic [NQ-1:0]        qhit_o,
    output logic [NQ*DATA_W-1:0] qdata_o,
    output logic [OCC_W-1:0]     occupancy_o
);

    // Stage records, stored field by field so the widths follow the
    // module parameters. Index 0 is the youngest stage.
    logic [DEPTH-1:0]             stageValid_q,    stageValid_d;
    logic [DEPTH-1:0]             stageRegWrite_q, stageRegWrite_d;
    logic [DEPTH-1:0][DATA_W-1:0] stageData_q,     stageData_d;
    logic [DEPTH-1:0][ADDR_W-1:0] stageRdAddr_q,   stageRdAddr_d;

    logic [MAX_DEPTH-1:0]         validPad;

    // Next-state for the chain. Flush wins over stall: only the valid bits
    // are cleared, the payload fields are left alone since nothing reads
    // them once valid is low and RegWrite_o is gated by valid. Without
    // stall or flush the inputs enter stage 0 and everything moves one
    // stage older; a bubble (valid_i=0) moves exactly like a live slot.
    always_comb begin
        stageValid_d    = stageValid_q;
        stageRegWrite_d = stageRegWrite_q;
        stageData_d     = stageData_q;
        stageRdAddr_d   = stageRdAddr_q;
        if (flush_i) begin
            stageValid_d = '0;
        end else if (!stall_i) begin
            stageValid_d[0]    = valid_i;
            stageRegWrite_d[0] = RegWrite_i;
            stageData_d[0]     = data_i;
            stageRdAddr_d[0]   = RDaddr_i;
            for (int k = 1; k < DEPTH; k++) begin
                stageValid_d[k]    = stageValid_q[k-1];
                stageRegWrite_d[k] = stageRegWrite_q[k-1];
                stageData_d[k]     = stageData_q[k-1];
                stageRdAddr_d[k]   = stageRdAddr_q[k-1];
            end
        end
    end

    // Stage registers. Reset clears every field of every stage and takes
    // priority over stall and flush, so nothing in flight survives it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stageValid_q    <= '0;
            stageRegWrite_q <= '0;
            stageData_q     <= '0;
            stageRdAddr_q   <= '0;
        end else begin
            stageValid_q    <= stageValid_d;
            stageRegWrite_q <= stageRegWrite_d;
            stageData_q     <= stageData_d;
            stageRdAddr_q   <= stageRdAddr_d;
        end
    end

    // The last stage drives the outputs. RegWrite_o is gated by valid so a
    // flushed slot that still carries RegWrite=1 can never write.
    assign valid_o    = stageValid_q[DEPTH-1];
    assign RegWrite_o = stageValid_q[DEPTH-1] & stageRegWrite_q[DEPTH-1];
    assign data_o     = stageData_q[DEPTH-1];
    assign RDaddr_o   = stageRdAddr_q[DEPTH-1];

    // Occupancy is derived from the valid bits rather than kept as a
    // separate counter, so it cannot drift from the real stage contents.
    always_comb begin
        validPad               = '0;
        validPad[DEPTH-1:0]    = stageValid_q;
    end

    assign occupancy_o = OCC_W'(countValid(validPad));

    // One priority mux per query port, all looking only at the stage
    // registers so forwarding never sees the same-cycle inputs.
    for (genvar q = 0; q < NQ; q++) begin : gFwd
        pipe_fwd_mux #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) uFwdMux (
            .stageValid_i    (stageValid_q),
            .stageRegWrite_i (stageRegWrite_q),
            .stageData_i     (stageData_q),
            .stageRdAddr_i   (stageRdAddr_q),
            .qaddr_i         (qaddr_i[q*ADDR_W +: ADDR_W]),
            .hit_o           (qhit_o[q]),
            .data_o          (qdata_o[q*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_chain
//
// Purpose:
//    Directed self-checking bench for pipe_stage_chain at DEPTH=2, NQ=2:
//    reset, streaming latency, stall, flush-with-stall, forwarding priority,
//    non-writer queries, mid-stream reset and a random streaming phase
//    checked against a fixed-latency expected-result queue.
// ---------------------------------------------------------------------------
module tb_pipe_stage_chain;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2;
    localparam int NQ     = 2;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 valid_i;
    logic                 RegWrite_i;
    logic [DATA_W-1:0]    data_i;
    logic [ADDR_W-1:0]    RDaddr_i;
    logic                 stall_i;
    logic                 flush_i;
    logic [NQ*ADDR_W-1:0] qaddr_i;
    logic                 valid_o;
    logic                 RegWrite_o;
    logic [DATA_W-1:0]    data_o;
    logic [ADDR_W-1:0]    RDaddr_o;
    logic [NQ-1:0]        qhit_o;
    logic [NQ*DATA_W-1:0] qdata_o;
    logic [OCC_W-1:0]     occupancy_o;

    typedef struct {
        logic              valid;
        logic              rw;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] rd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk_i = ~clk_i;

    pipe_stage_chain #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NQ     (NQ)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .RegWrite_i  (RegWrite_i),
        .data_i      (data_i),
        .RDaddr_i    (RDaddr_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .qaddr_i     (qaddr_i),
        .valid_o     (valid_o),
        .RegWrite_o  (RegWrite_o),
        .data_o      (data_o),
        .RDaddr_o    (RDaddr_o),
        .qhit_o      (qhit_o),
        .qdata_o     (qdata_o),
        .occupancy_o (occupancy_o)
    );

    // Advance one rising edge and settle 1 time unit past it, so inputs
    // are driven and outputs sampled away from the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one incoming slot together with the stall/flush controls.
    task automatic applyStimulus(input logic v, input logic rw,
                                 input logic [DATA_W-1:0] d,
                                 input logic [ADDR_W-1:0] rd,
                                 input logic st, input logic fl);
        valid_i    = v;
        RegWrite_i = rw;
        data_i     = d;
        RDaddr_i   = rd;
        stall_i    = st;
        flush_i    = fl;
    endtask

    // One counted comparison.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every output must read zero, as after a reset.
    task automatic checkAllZero(input string tag);
        checkOutput({tag, " valid_o"},     64'(valid_o),     64'(0));
        checkOutput({tag, " RegWrite_o"},  64'(RegWrite_o),  64'(0));
        checkOutput({tag, " data_o"},      64'(data_o),      64'(0));
        checkOutput({tag, " RDaddr_o"},    64'(RDaddr_o),    64'(0));
        checkOutput({tag, " qhit_o"},      64'(qhit_o),      64'(0));
        checkOutput({tag, " qdata_o"},     64'(qdata_o),     64'(0));
        checkOutput({tag, " occupancy_o"}, 64'(occupancy_o), 64'(0));
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_i   = 1'b1;
        qaddr_i = {5'd3, 5'd5};
        applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        step();
        rst_i = 1'b0;
        checkAllZero("reset");

        // ---------------- streaming latency ----------------
        applyStimulus(1'b1, 1'b1, 32'hAAAA0001, 5'd5, 1'b0, 1'b0);
        step();
        checkOutput("stream e1 valid_o", 64'(valid_o), 64'(0));
        checkOutput("stream e1 occ", 64'(occupancy_o), 64'(1));
        applyStimulus(1'b1, 1'b1, 32'hBBBB0002, 5'd6, 1'b0, 1'b0);
        step();
        checkOutput("stream e2 valid_o", 64'(valid_o), 64'(1));
        checkOutput("stream e2 RDaddr_o", 64'(RDaddr_o), 64'(5));
        checkOutput("stream e2 data_o", 64'(data_o), 64'(32'hAAAA0001));
        checkOutput("stream e2 RegWrite_o", 64'(RegWrite_o), 64'(1));
        checkOutput("stream e2 occ", 64'(occupancy_o), 64'(2));
        applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        checkOutput("stream e3 data_o", 64'(data_o), 64'(32'hBBBB0002));
        checkOutput("stream e3 RDaddr_o", 64'(RDaddr_o), 64'(6));
        checkOutput("stream e3 occ", 64'(occupancy_o), 64'(1));
        step();
        checkOutput("stream e4 valid_o", 64'(valid_o), 64'(0));
        checkOutput("stream e4 occ", 64'(occupancy_o), 64'(0));

        // ---------------- stall ----------------
        applyStimulus(1'b1, 1'b1, 32'hC0C00009, 5'd9, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 32'hD0D0000A, 5'd10, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'hEEEE0000 + 32'(i), 5'd11, 1'b1, 1'b0);
            step();
            checkOutput("stall data_o", 64'(data_o), 64'(32'hC0C00009));
            checkOutput("stall RDaddr_o", 64'(RDaddr_o), 64'(9));
            checkOutput("stall valid_o", 64'(valid_o), 64'(1));
            checkOutput("stall occ", 64'(occupancy_o), 64'(2));
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        checkOutput("release data_o", 64'(data_o), 64'(32'hD0D0000A));
        checkOutput("release RDaddr_o", 64'(RDaddr_o), 64'(10));
        checkOutput("release RegWrite_o", 64'(RegWrite_o), 64'(0));
        checkOutput("release occ", 64'(occupancy_o), 64'(1));
        step();
        checkOutput("drain occ", 64'(occupancy_o), 64'(0));

        // ---------------- forwarding priority ----------------
        applyStimulus(1'b1, 1'b1, 32'h11, 5'd7, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 1'b1, 32'h22, 5'd7, 1'b0, 1'b0);
        step();
        qaddr_i = {5'd0, 5'd7};
        applyStimulus(1'b1, 1'b1, 32'hDEAD, 5'd7, 1'b0, 1'b0);
        #1;
        checkOutput("fwd qhit", 64'(qhit_o), 64'(2'b01));
        checkOutput("fwd qdata", 64'(qdata_o), 64'h0000_0000_0000_0022);
        qaddr_i = {5'd7, 5'd0};
        #1;
        checkOutput("fwd swap qhit", 64'(qhit_o), 64'(2'b10));
        checkOutput("fwd swap qdata", 64'(qdata_o), 64'h0000_0022_0000_0000);

        // ---------------- non-writers ----------------
        applyStimulus(1'b1, 1'b0, 32'h33, 5'd3, 1'b0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b1, 32'h44, 5'd3, 1'b0, 1'b0);
        step();
        qaddr_i = {5'd3, 5'd3};
        #1;
        checkOutput("nowr qhit", 64'(qhit_o), 64'(0));
        checkOutput("nowr qdata", 64'(qdata_o), 64'(0));
        checkOutput("nowr valid_o", 64'(valid_o), 64'(1));
        checkOutput("nowr RegWrite_o", 64'(RegWrite_o), 64'(0));
        applyStimulus(1'b1, 1'b1, 32'h55, 5'd3, 1'b0, 1'b0);
        step();
        checkOutput("young hit qhit", 64'(qhit_o), 64'(2'b11));
        checkOutput("young hit qdata", 64'(qdata_o), 64'h0000_0055_0000_0055);
        applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        checkOutput("old hit qhit", 64'(qhit_o), 64'(2'b11));
        checkOutput("old hit qdata", 64'(qdata_o), 64'h0000_0055_0000_0055);
        step();

        // ---------------- flush with stall ----------------
        applyStimulus(1'b1, 1'b1, 32'h1212, 5'd12, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 1'b1, 32'h1313, 5'd13, 1'b0, 1'b0);
        step();
        checkOutput("preflush occ", 64'(occupancy_o), 64'(2));
        qaddr_i = {5'd14, 5'd12};
        applyStimulus(1'b1, 1'b1, 32'h9999, 5'd14, 1'b1, 1'b1);
        step();
        checkOutput("flush occ", 64'(occupancy_o), 64'(0));
        checkOutput("flush RegWrite_o", 64'(RegWrite_o), 64'(0));
        checkOutput("flush valid_o", 64'(valid_o), 64'(0));
        checkOutput("flush qhit", 64'(qhit_o), 64'(0));
        applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("flush drop valid_o", 64'(valid_o), 64'(0));
            checkOutput("flush drop occ", 64'(occupancy_o), 64'(0));
        end

        // ---------------- mid-stream reset ----------------
        applyStimulus(1'b1, 1'b1, 32'h1515, 5'd15, 1'b0, 1'b0);
        step();
        applyStimulus(1'b1, 1'b1, 32'h1616, 5'd16, 1'b0, 1'b0);
        step();
        checkOutput("prerst occ", 64'(occupancy_o), 64'(2));
        qaddr_i = {5'd16, 5'd15};
        rst_i   = 1'b1;
        applyStimulus(1'b1, 1'b1, 32'h1717, 5'd17, 1'b0, 1'b0);
        step();
        rst_i = 1'b0;
        checkAllZero("midrst");
        applyStimulus(1'b1, 1'b1, 32'h1818, 5'd18, 1'b0, 1'b0);
        step();
        checkOutput("postrst e1 valid_o", 64'(valid_o), 64'(0));
        checkOutput("postrst e1 occ", 64'(occupancy_o), 64'(1));
        applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        checkOutput("postrst e2 valid_o", 64'(valid_o), 64'(1));
        checkOutput("postrst e2 data_o", 64'(data_o), 64'(32'h1818));
        checkOutput("postrst e2 RDaddr_o", 64'(RDaddr_o), 64'(18));

        // ---------------- random streaming, queued expectations ----------------
        for (int i = 0; i < 24; i++) begin
            exp_t e;
            exp_t x;
            e.valid = 1'($urandom_range(0, 1));
            e.rw    = 1'($urandom_range(0, 1));
            e.data  = $urandom;
            e.rd    = 5'($urandom_range(0, 31));
            applyStimulus(e.valid, e.rw, e.data, e.rd, 1'b0, 1'b0);
            sb.push_back(e);
            step();
            if (sb.size() == DEPTH) begin
                x = sb.pop_front();
                checkOutput("sb valid_o", 64'(valid_o), 64'(x.valid));
                checkOutput("sb RegWrite_o", 64'(RegWrite_o), 64'(x.valid & x.rw));
                if (x.valid) begin
                    checkOutput("sb data_o", 64'(data_o), 64'(x.data));
                    checkOutput("sb RDaddr_o", 64'(RDaddr_o), 64'(x.rd));
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
